vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port, synchronous-read frame-buffer RAM between two users: display scan-out, which has fixed priority, and an asynchronous pixel writer (UART/CPU side).
- Sits between the VGA sync pulse generator (row/col counters) and the colour output stage.
- Each logical cell covers a 2^SCALE_LOG2 x 2^SCALE_LOG2 pixel square.
- Writer traffic is buffered in a small FIFO and drained only on cycles the display does not use the RAM.

Parameters:
- ACTIVE_COLS, 640, visible pixel columns
- ACTIVE_ROWS, 480, visible pixel rows
- SCALE_LOG2, 3, log2 of pixel replication per cell; LOGICAL_COLS = ACTIVE_COLS>>SCALE_LOG2, LOGICAL_ROWS = ACTIVE_ROWS>>SCALE_LOG2
- ADDR_W, 13, RAM address width; must hold LOGICAL_COLS*LOGICAL_ROWS
- DATA_W, 9, cell colour width
- FIFO_DEPTH, 4, write FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- row  in  10  current scan row from the sync generator
- col  in  10  current scan column from the sync generator
- wr_valid  in  1  writer request
- wr_ready  out  1  FIFO not full
- wr_addr  in  ADDR_W  cell address
- wr_data  in  DATA_W  cell colour
- wr_oob  out  1  one-cycle pulse: an accepted write was out of range and dropped
- mem_addr  out  ADDR_W  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  DATA_W  RAM write data (combinational)
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented
- pix_valid  out  1  pix_data is an active pixel
- pix_data  out  DATA_W  colour for (row,col) presented 2 cycles earlier

Behaviour:
- active = (col < ACTIVE_COLS) && (row < ACTIVE_ROWS).
- fetch = active && (col[SCALE_LOG2-1:0] == 0); if SCALE_LOG2 == 0, fetch = active.
- Display read on a fetch cycle:
  - mem_we = 0.
  - mem_addr = (row>>SCALE_LOG2)*LOGICAL_COLS + (col>>SCALE_LOG2), computed modulo 2^ADDR_W.
  - The display has absolute priority; a write is never issued on a fetch cycle.
- Pixel pipeline, latency 2:
  - Stage 1 registers active and fetch.
  - Stage 2, if stage-1 fetch: pix_data <= mem_rdata and hold <= mem_rdata.
  - Stage 2, else if stage-1 active: pix_data <= hold.
  - Stage 2, else: pix_data <= 0.
  - pix_valid <= stage-1 active.
  - The instantiator delays HSync/VSync by 2 to match.
- Write FIFO:
  - Push when wr_valid && wr_ready; wr_ready = (count < FIFO_DEPTH).
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - No pass-through when full: wr_ready is low even if a pop occurs that cycle.
- Out-of-range writes:
  - On push, if wr_addr >= LOGICAL_COLS*LOGICAL_ROWS, the entry is accepted but not stored.
  - wr_oob pulses high on the following cycle (registered).
- Drain:
  - On any cycle with !fetch && count > 0: mem_we = 1, mem_addr = head addr, mem_wdata = head data, pop.
  - Entries are written in push order, one per cycle.
- Idle cycle (no fetch, FIFO empty): mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Wrap-around: row/col wrap is handled by the sync generator; this block is stateless with respect to frame position beyond the 2-stage pipeline.
- Reset:
  - Reset values: count = 0, read/write pointers = 0, wr_ready = 1, wr_oob = 0, pix_valid = 0, pix_data = 0, hold = 0, stage-1 flags = 0.
  - A reset mid-frame discards all FIFO contents; no partial write is issued.
  - mem_we drops immediately, since it is derived from count = 0.

Optional Feature:
- Macro: VGA_FB_WR_BLANK_ONLY_EN.
- When defined, draining is permitted only when row >= ACTIVE_ROWS (vertical blanking), giving tear-free updates. All other behaviour is unchanged; the FIFO fills and back-pressures during the visible frame.
- When undefined, draining occurs on any non-fetch cycle, as described above.

Test Plan:
- Reset: assert rst mid-frame with 3 entries queued -> pix_valid = 0, pix_data = 0, mem_we = 0, wr_ready = 1 immediately; no further writes after release.
- Display fetch (SCALE_LOG2=3): row=16, col=24 -> mem_addr = 163, mem_we = 0; RAM returns 0x1AA -> pix_data = 0x1AA, pix_valid = 1 two cycles later, held for cols 24..31 with no further reads until col = 32.
- Write in active gap: push addr 5 / data 0x0F3 at row=0, col=8 -> mem_we never high at col=8 or col=16; write lands at col=9 with mem_addr = 5, mem_wdata = 0x0F3.
- Back-pressure (SCALE_LOG2=0): at row=10, col=0 push 5 entries back-to-back -> 4 accepted, wr_ready low from the 5th cycle; all 4 drained in order on cols 640..643; wr_ready then high.
- Out of range: push wr_addr = 4800 -> handshake completes, wr_oob = 1 for exactly one cycle, no mem_we for that entry.
- Macro defined: push addr 7 at row=100 -> mem_we stays 0 through row 479; write issued on the first cycle with row = 480.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer RAM arbiter: display scan-out with priority, buffered pixel writer
//
// Purpose:
//   Shares one single-port, synchronous-read frame-buffer RAM between VGA
//   scan-out and a pixel writer. The display fetches one cell per
//   2^SCALE_LOG2 columns of the active area and always wins. Writer requests
//   queue in a small FIFO and drain on cycles the display leaves the RAM idle.
//   Pixel output lags (row, col) by two cycles.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   row, col            current scan position from the sync generator
//   wr_valid/wr_ready   writer handshake (wr_ready = FIFO not full)
//   wr_addr, wr_data    cell address and colour of a write
//   wr_oob              one-cycle pulse after an out-of-range write was accepted and dropped
//   mem_addr/we/wdata   RAM request (combinational)
//   mem_rdata           RAM read data, one cycle after the address
//   pix_valid, pix_data colour for the position presented two cycles earlier
//
// Optional feature:
//   VGA_FB_WR_BLANK_ONLY_EN - when defined, the write FIFO drains only during
//   vertical blanking (row >= ACTIVE_ROWS), giving tear-free updates.

module vga_fb_arbiter #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int SCALE_LOG2  = 3,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 9,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_oob,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data
);

  localparam int LOGICAL_COLS = ACTIVE_COLS >> SCALE_LOG2;
  localparam int LOGICAL_ROWS = ACTIVE_ROWS >> SCALE_LOG2;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [31:0]      ACOLS_W   = ACTIVE_COLS;
  localparam logic [31:0]      AROWS_W   = ACTIVE_ROWS;
  localparam logic [31:0]      CELLS_W   = LOGICAL_COLS * LOGICAL_ROWS;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  // Scan-position decode
  logic              active;
  logic              fetch;
  logic [ADDR_W-1:0] disp_addr;

  assign active = (32'(col) < ACOLS_W) && (32'(row) < AROWS_W);

  generate
    if (SCALE_LOG2 == 0) begin : g_fetch_every
      assign fetch = active;
    end else begin : g_fetch_cell
      assign fetch = active && (col[SCALE_LOG2-1:0] == '0);
    end
  endgenerate

  // Arithmetic carried out in ADDR_W bits wraps modulo 2^ADDR_W by construction.
  assign disp_addr = ADDR_W'(row >> SCALE_LOG2) * ADDR_W'(LOGICAL_COLS)
                   + ADDR_W'(col >> SCALE_LOG2);

  // Write FIFO
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_oob_q, wr_oob_d;
  logic              push_hs;
  logic              in_range;
  logic              store;
  logic              drain_window;
  logic              drain;

  // Ready depends only on the registered count, so a full FIFO never
  // accepts a new entry even when it pops in the same cycle.
  assign wr_ready = count_q < FIFO_FULL;
  assign push_hs  = wr_valid && wr_ready;
  assign in_range = 32'(wr_addr) < CELLS_W;
  // Out-of-range writes complete the handshake but never occupy a slot.
  assign store    = push_hs && in_range;

`ifdef VGA_FB_WR_BLANK_ONLY_EN
  assign drain_window = 32'(row) >= AROWS_W;
`else
  assign drain_window = 1'b1;
`endif

  assign drain = !fetch && (count_q != '0) && drain_window;

  assign rd_ptr_d = rd_ptr_q + PTR_W'(drain);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(store);
  assign count_d  = count_q + CNT_W'(store) - CNT_W'(drain);
  assign wr_oob_d = push_hs && !in_range;
  assign wr_oob   = wr_oob_q;

  // FIFO storage needs no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // RAM port mux: display read, else FIFO drain, else idle zeros
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch) begin
      mem_addr = disp_addr;
    end else if (drain) begin
      mem_we    = 1'b1;
      mem_addr  = fifo_addr_q[rd_ptr_q];
      mem_wdata = fifo_data_q[rd_ptr_q];
    end
  end

  // Pixel pipeline: stage 1 flags, stage 2 colour
  logic              act1_q, act1_d;
  logic              fetch1_q, fetch1_d;
  logic              pix_valid_q, pix_valid_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    act1_d      = active;
    fetch1_d    = fetch;
    pix_valid_d = act1_q;
    hold_d      = hold_q;
    pix_data_d  = '0;
    if (fetch1_q) begin
      // RAM data for the fetch issued last cycle arrives now; keep it
      // for the remaining columns of the cell.
      pix_data_d = mem_rdata;
      hold_d     = mem_rdata;
    end else if (act1_q) begin
      pix_data_d = hold_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wr_oob_q    <= 1'b0;
      act1_q      <= 1'b0;
      fetch1_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      hold_q      <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wr_oob_q    <= wr_oob_d;
      act1_q      <= act1_d;
      fetch1_q    <= fetch1_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      hold_q      <= hold_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter with a queue-based reference model
`timescale 1ns/1ps

module tb_vga_fb_arbiter;

  logic        clk;
  logic        rst;
  logic [9:0]  row, col;
  logic        wr_valid, wr_valid0;
  logic [12:0] wr_addr;
  logic [18:0] wr_addr0;
  logic [8:0]  wr_data;
  logic [8:0]  mem_rdata, mem_rdata0;

  logic        wr_ready, wr_oob, mem_we, pix_valid;
  logic [12:0] mem_addr;
  logic [8:0]  mem_wdata, pix_data;

  logic        wr_ready0, wr_oob0, mem_we0, pix_valid0;
  logic [18:0] mem_addr0;
  logic [8:0]  mem_wdata0, pix_data0;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_oob(wr_oob), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_data(pix_data)
  );

  // One cell per pixel: every active column is a display fetch.
  vga_fb_arbiter #(.SCALE_LOG2(0), .ADDR_W(19)) dut0 (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .wr_valid(wr_valid0), .wr_ready(wr_ready0), .wr_addr(wr_addr0), .wr_data(wr_data),
    .wr_oob(wr_oob0), .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .pix_valid(pix_valid0), .pix_data(pix_data0)
  );

  // Frame-buffer contents seen by the display
  function automatic logic [8:0] rom(input logic [12:0] a);
    if (a == 13'd163) return 9'h1AA;
    return a[8:0] ^ {a[12:9], 5'h15};
  endfunction

  // Sampled outputs
  logic        s_we, s_ready, s_oob, s_pv;
  logic [12:0] s_addr;
  logic [8:0]  s_wdata, s_pd;
  logic        s0_we, s0_ready;
  logic [18:0] s0_addr;
  logic [8:0]  s0_wdata;

  task automatic tick();
    @(negedge clk);
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    s_ready = wr_ready; s_oob = wr_oob; s_pv = pix_valid; s_pd = pix_data;
    s0_we = mem_we0; s0_addr = mem_addr0; s0_wdata = mem_wdata0; s0_ready = wr_ready0;
    @(posedge clk);
    #1;
    mem_rdata = rom(s_addr);
  endtask

  // Reference model of the default-parameter instance
  typedef struct packed {
    logic [12:0] a;
    logic [8:0]  d;
  } wr_t;

  wr_t         mq[$];
  bit          m_oob;
  logic [8:0]  m_hold;
  bit          m_pv1, m_pv2;
  logic [8:0]  m_pd1, m_pd2;
  bit          e_we, e_ready, e_oob, e_pv, e_act, e_fch;
  logic [12:0] e_addr;
  logic [8:0]  e_wdata, e_pd;

  task automatic model_reset();
    mq.delete();
    m_oob = 0; m_hold = '0;
    m_pv1 = 0; m_pv2 = 0; m_pd1 = '0; m_pd2 = '0;
  endtask

  task automatic model_predict();
    int r, c;
    bit blank_ok;
    r = int'(row);
    c = int'(col);
`ifdef VGA_FB_WR_BLANK_ONLY_EN
    blank_ok = (r >= 480);
`else
    blank_ok = 1;
`endif
    e_act   = (c < 640) && (r < 480);
    e_fch   = e_act && (c % 8 == 0);
    e_ready = mq.size() < 4;
    e_oob   = m_oob;
    e_pv    = m_pv2;
    e_pd    = m_pd2;
    e_we = 0; e_addr = '0; e_wdata = '0;
    if (e_fch) begin
      e_addr = 13'(((r / 8) * 80 + c / 8) % 8192);
    end else if (mq.size() > 0 && blank_ok) begin
      e_we = 1; e_addr = mq[0].a; e_wdata = mq[0].d;
    end
  endtask

  task automatic model_commit();
    logic [8:0] v;
    bit acc;
    if (e_fch) begin
      v = rom(e_addr); m_hold = v;
    end else if (e_act) v = m_hold;
    else v = '0;
    m_pv2 = m_pv1; m_pd2 = m_pd1;
    m_pv1 = e_act; m_pd1 = v;
    if (e_we) void'(mq.pop_front());
    acc   = wr_valid && e_ready;
    m_oob = acc && (int'(wr_addr) >= 4800);
    if (acc && int'(wr_addr) < 4800) mq.push_back('{a: wr_addr, d: wr_data});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 0; wr_valid0 = 0; wr_addr = '0; wr_addr0 = '0; wr_data = '0;
    row = 10'd500; col = 10'd700; mem_rdata = '0; mem_rdata0 = 9'h155;
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", s_we); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", s_ready); end
    checks++; if (s_oob !== 1'b0) begin errors++; $display("FAIL reset_oob got %0b exp 0", s_oob); end
    checks++; if (s_pv !== 1'b0 || s_pd !== 9'h0) begin errors++; $display("FAIL reset_pix got %0b/%h exp 0/000", s_pv, s_pd); end
    // queue 3 entries in dut0 during the active area, where it cannot drain
    row = 10'd10;
    for (int i = 0; i < 5; i++) begin
      col = 10'(i);
      wr_valid0 = (i < 3);
      wr_addr0 = 19'(200 + i);
      wr_data = 9'(16 + i);
      tick();
    end
    wr_valid0 = 0;
    col = 10'd640;
    #1;
    checks++; if (mem_we0 !== 1'b1) begin errors++; $display("FAIL reset_pre_we0 got %0b exp 1", mem_we0); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we0 !== 1'b0) begin errors++; $display("FAIL reset_async_we0 got %0b exp 0", mem_we0); end
    checks++; if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL reset_async_ready0 got %0b exp 1", wr_ready0); end
    checks++; if (pix_valid !== 1'b0 || pix_data !== 9'h0) begin errors++; $display("FAIL reset_async_pix got %0b/%h exp 0/000", pix_valid, pix_data); end
    checks++; if (pix_valid0 !== 1'b0 || pix_data0 !== 9'h0) begin errors++; $display("FAIL reset_async_pix0 got %0b/%h exp 0/000", pix_valid0, pix_data0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      col = 10'(641 + i);
      tick();
      checks++; if (s0_we !== 1'b0) begin errors++; $display("FAIL reset_after_we0 cyc %0d got %0b exp 0", i, s0_we); end
    end
  endtask

  task automatic test_fetch();
    do_reset();
    row = 10'd16;
    for (int i = 0; i < 10; i++) begin
      col = 10'(24 + i);
      tick();
      if (i == 0) begin
        checks++; if (s_addr !== 13'd163 || s_we !== 1'b0) begin errors++; $display("FAIL fetch_addr got %0d/%0b exp 163/0", s_addr, s_we); end
      end else if (i < 8) begin
        checks++; if (s_addr !== 13'd0 || s_we !== 1'b0) begin errors++; $display("FAIL fetch_noread col %0d got %0d/%0b exp 0/0", 24 + i, s_addr, s_we); end
      end else if (i == 8) begin
        checks++; if (s_addr !== 13'd164 || s_we !== 1'b0) begin errors++; $display("FAIL fetch_next got %0d/%0b exp 164/0", s_addr, s_we); end
      end
      if (i >= 2) begin
        checks++; if (s_pv !== 1'b1 || s_pd !== 9'h1AA) begin errors++; $display("FAIL fetch_pix col %0d got %0b/%h exp 1/1aa", 22 + i, s_pv, s_pd); end
      end
    end
  endtask

  task automatic test_active_gap();
    do_reset();
    row = 10'd0;
    wr_addr = 13'd5;
    wr_data = 9'h0F3;
    for (int i = 0; i < 10; i++) begin
      col = 10'(8 + i);
      wr_valid = (i == 0);
      tick();
      if (i == 1) begin
        checks++; if (s_we !== 1'b1 || s_addr !== 13'd5 || s_wdata !== 9'h0F3) begin
          errors++; $display("FAIL gap_write got %0b/%0d/%h exp 1/5/0f3", s_we, s_addr, s_wdata);
        end
      end else begin
        checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL gap_nowrite col %0d got %0b exp 0", 8 + i, s_we); end
      end
    end
    wr_valid = 0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    row = 10'd10;
    for (int i = 0; i < 5; i++) begin
      col = 10'(i);
      wr_valid0 = 1;
      wr_addr0 = 19'(300 + i);
      wr_data = 9'(64 + i);
      tick();
      checks++; if (s0_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready push %0d got %0b exp %0b", i, s0_ready, (i < 4)); end
      checks++; if (s0_we !== 1'b0) begin errors++; $display("FAIL bp_nowrite push %0d got %0b exp 0", i, s0_we); end
    end
    wr_valid0 = 0;
    col = 10'd639;
    tick();
    checks++; if (s0_we !== 1'b0) begin errors++; $display("FAIL bp_fetch_we got %0b exp 0", s0_we); end
    for (int i = 0; i < 4; i++) begin
      col = 10'(640 + i);
      tick();
      checks++; if (s0_we !== 1'b1 || s0_addr !== 19'(300 + i) || s0_wdata !== 9'(64 + i)) begin
        errors++; $display("FAIL bp_drain %0d got %0b/%0d/%h exp 1/%0d/%h", i, s0_we, s0_addr, s0_wdata, 300 + i, 64 + i);
      end
    end
    col = 10'd644;
    tick();
    checks++; if (s0_we !== 1'b0 || s0_ready !== 1'b1) begin errors++; $display("FAIL bp_empty got we %0b ready %0b exp 0/1", s0_we, s0_ready); end
  endtask

  task automatic test_oob();
    do_reset();
    row = 10'd500;
    col = 10'd0; wr_valid = 1; wr_addr = 13'd4800; wr_data = 9'h1FF;
    tick();
    checks++; if (s_ready !== 1'b1 || s_oob !== 1'b0) begin errors++; $display("FAIL oob_accept got ready %0b oob %0b exp 1/0", s_ready, s_oob); end
    wr_valid = 0; col = 10'd1;
    tick();
    checks++; if (s_oob !== 1'b1 || s_we !== 1'b0) begin errors++; $display("FAIL oob_pulse got oob %0b we %0b exp 1/0", s_oob, s_we); end
    col = 10'd2;
    tick();
    checks++; if (s_oob !== 1'b0 || s_we !== 1'b0) begin errors++; $display("FAIL oob_single got oob %0b we %0b exp 0/0", s_oob, s_we); end
    col = 10'd3; wr_valid = 1; wr_addr = 13'd4799;
    tick();
    wr_valid = 0; col = 10'd4;
    tick();
    checks++; if (s_oob !== 1'b0 || s_we !== 1'b1 || s_addr !== 13'd4799) begin
      errors++; $display("FAIL oob_last_cell got oob %0b we %0b addr %0d exp 0/1/4799", s_oob, s_we, s_addr);
    end
  endtask

`ifdef VGA_FB_WR_BLANK_ONLY_EN
  task automatic test_blank_only();
    do_reset();
    row = 10'd100; col = 10'd1; wr_valid = 1; wr_addr = 13'd7; wr_data = 9'h077;
    tick();
    wr_valid = 0;
    for (int i = 2; i < 12; i++) begin
      col = 10'(i);
      tick();
      checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL blank_row100 col %0d got %0b exp 0", i, s_we); end
    end
    row = 10'd479;
    for (int i = 790; i < 800; i++) begin
      col = 10'(i);
      tick();
      checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL blank_row479 col %0d got %0b exp 0", i, s_we); end
    end
    row = 10'd480; col = 10'd0;
    tick();
    checks++; if (s_we !== 1'b1 || s_addr !== 13'd7 || s_wdata !== 9'h077) begin
      errors++; $display("FAIL blank_row480 got %0b/%0d/%h exp 1/7/077", s_we, s_addr, s_wdata);
    end
  endtask
`endif

  task automatic test_random();
    int r, c;
    do_reset();
    r = 0; c = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) begin
        r = $urandom_range(524); c = $urandom_range(799);
      end else begin
        c++;
        if (c == 800) begin c = 0; r = (r == 524) ? 0 : r + 1; end
      end
      row = 10'(r); col = 10'(c);
      wr_valid = 1'($urandom_range(1));
      wr_addr = ($urandom_range(7) == 0) ? 13'($urandom_range(8191, 4800)) : 13'($urandom_range(4799));
      wr_data = 9'($urandom);
      model_predict();
      tick();
      checks++; if (s_we !== e_we) begin errors++; $display("FAIL rand_we cyc %0d got %0b exp %0b", i, s_we, e_we); end
      checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rand_addr cyc %0d got %0d exp %0d", i, s_addr, e_addr); end
      if (e_we) begin
        checks++; if (s_wdata !== e_wdata) begin errors++; $display("FAIL rand_wdata cyc %0d got %h exp %h", i, s_wdata, e_wdata); end
      end
      checks++; if (s_ready !== e_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %0b exp %0b", i, s_ready, e_ready); end
      checks++; if (s_oob !== e_oob) begin errors++; $display("FAIL rand_oob cyc %0d got %0b exp %0b", i, s_oob, e_oob); end
      checks++; if (s_pv !== e_pv) begin errors++; $display("FAIL rand_pix_valid cyc %0d got %0b exp %0b", i, s_pv, e_pv); end
      checks++; if (s_pd !== e_pd) begin errors++; $display("FAIL rand_pix_data cyc %0d got %h exp %h", i, s_pd, e_pd); end
      model_commit();
    end
    wr_valid = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_active_gap();
    test_back_pressure();
    test_oob();
`ifdef VGA_FB_WR_BLANK_ONLY_EN
    test_blank_only();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
